// File: rtl/rdmap_event_merge.sv
// RDMAP event merge: three per-source event FIFOs (ACK, offload, write-done)
// drained round-robin into one registered valid/ready completion-event stream.
module rdmap_event_merge #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ackFifoPush,
    input  logic [27:0] ackFifoDataIn,
    output logic        ackFifoFull,
    input  logic        offloadFifoPush,
    input  logic [7:0]  offloadFifoDataIn,
    output logic        offloadFifoFull,
    input  logic        wrDoneFifoPush,
    input  logic [7:0]  wrDoneFifoDataIn,
    output logic        wrDoneFifoFull,
    output logic        evtValid,
    input  logic        evtReady,
    output logic [1:0]  evtType,
    output logic [7:0]  evtTid,
    output logic [19:0] evtInfo,
    output logic        ovfErr
);

    localparam int NSRC = 3;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    // Source index 0=ACK, 1=OFFLOAD, 2=WR_DONE; entries are {tid, info}.
    logic [NSRC-1:0] push;
    logic [NSRC-1:0] full;
    logic [NSRC-1:0] empty;
    logic [NSRC-1:0] accept;
    logic [NSRC-1:0] pop;
    logic [27:0]     din      [NSRC];
    logic [27:0]     head     [NSRC];
    logic [27:0]     mem_q    [NSRC][DEPTH];
    logic [AW-1:0]   wrPtr_q  [NSRC];
    logic [AW-1:0]   wrPtr_d  [NSRC];
    logic [AW-1:0]   rdPtr_q  [NSRC];
    logic [AW-1:0]   rdPtr_d  [NSRC];
    logic [AW:0]     count_q  [NSRC];
    logic [AW:0]     count_d  [NSRC];

    logic            ovfErr_q;
    logic            ovfErr_d;
    logic [1:0]      rr_q;
    logic [1:0]      rr_d;
    logic            evtValid_q;
    logic            evtValid_d;
    logic [1:0]      evtType_q;
    logic [1:0]      evtType_d;
    logic [7:0]      evtTid_q;
    logic [7:0]      evtTid_d;
    logic [19:0]     evtInfo_q;
    logic [19:0]     evtInfo_d;

    logic            load;
    logic            found;
    logic [1:0]      grantIdx;
    logic [27:0]     grantData;

    assign push[0] = ackFifoPush;
    assign push[1] = offloadFifoPush;
    assign push[2] = wrDoneFifoPush;
    assign din[0]  = ackFifoDataIn;
    assign din[1]  = {offloadFifoDataIn, 20'd0};
    assign din[2]  = {wrDoneFifoDataIn, 20'd0};

    // Status flags decoded from the registered occupancy counts.
    always_comb begin
        for (int s = 0; s < NSRC; s++) begin
            full[s]   = (count_q[s] == FULL_CNT);
            empty[s]  = (count_q[s] == '0);
            accept[s] = push[s] & ~full[s];
            head[s]   = mem_q[s][rdPtr_q[s]];
        end
    end

    // Round-robin search starting at rr_q; first non-empty source wins.
    always_comb begin
        found    = 1'b0;
        grantIdx = 2'd0;
        for (int k = 0; k < NSRC; k++) begin
            int j;
            j = (int'(rr_q) + k) % NSRC;
            if (!found && !empty[j]) begin
                found    = 1'b1;
                grantIdx = 2'(j);
            end
        end
    end

    assign load = (~evtValid_q | evtReady) & found;

    // Head of the granted FIFO and one-hot pop strobe.
    always_comb begin
        pop       = '0;
        grantData = head[0];
        case (grantIdx)
            2'd1:    grantData = head[1];
            2'd2:    grantData = head[2];
            default: grantData = head[0];
        endcase
        if (load) begin
            pop[grantIdx] = 1'b1;
        end
    end

    // FIFO pointer/count next state; sticky overflow on push-while-full.
    always_comb begin
        ovfErr_d = ovfErr_q;
        for (int s = 0; s < NSRC; s++) begin
            wrPtr_d[s] = wrPtr_q[s] + AW'(accept[s]);
            rdPtr_d[s] = rdPtr_q[s] + AW'(pop[s]);
            count_d[s] = count_q[s];
            if (accept[s] && !pop[s]) begin
                count_d[s] = count_q[s] + 1'b1;
            end else if (!accept[s] && pop[s]) begin
                count_d[s] = count_q[s] - 1'b1;
            end
            if (push[s] && full[s]) begin
                ovfErr_d = 1'b1;
            end
        end
    end

    // Output register and RR pointer next state.
    always_comb begin
        evtValid_d = evtValid_q;
        evtType_d  = evtType_q;
        evtTid_d   = evtTid_q;
        evtInfo_d  = evtInfo_q;
        rr_d       = rr_q;
        if (load) begin
            evtValid_d = 1'b1;
            evtType_d  = grantIdx;
            evtTid_d   = grantData[27:20];
            evtInfo_d  = grantData[19:0];
            rr_d       = (grantIdx == 2'd2) ? 2'd0 : grantIdx + 2'd1;
        end else if (evtValid_q && evtReady) begin
            evtValid_d = 1'b0;
        end
    end

    // FIFO storage writes; contents need no reset since counts gate reads.
    always_ff @(posedge clock) begin
        for (int s = 0; s < NSRC; s++) begin
            if (accept[s]) begin
                mem_q[s][wrPtr_q[s]] <= din[s];
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < NSRC; s++) begin
                wrPtr_q[s] <= '0;
                rdPtr_q[s] <= '0;
                count_q[s] <= '0;
            end
            ovfErr_q   <= 1'b0;
            rr_q       <= 2'd0;
            evtValid_q <= 1'b0;
            evtType_q  <= 2'd0;
            evtTid_q   <= 8'd0;
            evtInfo_q  <= 20'd0;
        end else begin
            for (int s = 0; s < NSRC; s++) begin
                wrPtr_q[s] <= wrPtr_d[s];
                rdPtr_q[s] <= rdPtr_d[s];
                count_q[s] <= count_d[s];
            end
            ovfErr_q   <= ovfErr_d;
            rr_q       <= rr_d;
            evtValid_q <= evtValid_d;
            evtType_q  <= evtType_d;
            evtTid_q   <= evtTid_d;
            evtInfo_q  <= evtInfo_d;
        end
    end

    assign ackFifoFull     = full[0];
    assign offloadFifoFull = full[1];
    assign wrDoneFifoFull  = full[2];
    assign evtValid        = evtValid_q;
    assign evtType         = evtType_q;
    assign evtTid          = evtTid_q;
    assign evtInfo         = evtInfo_q;
    assign ovfErr          = ovfErr_q;

endmodule

// File: tb/tb_rdmap_event_merge.sv
// Directed bench for rdmap_event_merge: reset, latency, RR order,
// overflow, back-pressure and mid-operation reset.
module tb_rdmap_event_merge;

    logic        clk = 1'b0;
    logic        reset;
    logic        ackFifoPush;
    logic [27:0] ackFifoDataIn;
    logic        ackFifoFull;
    logic        offloadFifoPush;
    logic [7:0]  offloadFifoDataIn;
    logic        offloadFifoFull;
    logic        wrDoneFifoPush;
    logic [7:0]  wrDoneFifoDataIn;
    logic        wrDoneFifoFull;
    logic        evtValid;
    logic        evtReady;
    logic [1:0]  evtType;
    logic [7:0]  evtTid;
    logic [19:0] evtInfo;
    logic        ovfErr;

    int checks = 0;
    int failures = 0;

    rdmap_event_merge dut (
        .clock             (clk),
        .reset             (reset),
        .ackFifoPush       (ackFifoPush),
        .ackFifoDataIn     (ackFifoDataIn),
        .ackFifoFull       (ackFifoFull),
        .offloadFifoPush   (offloadFifoPush),
        .offloadFifoDataIn (offloadFifoDataIn),
        .offloadFifoFull   (offloadFifoFull),
        .wrDoneFifoPush    (wrDoneFifoPush),
        .wrDoneFifoDataIn  (wrDoneFifoDataIn),
        .wrDoneFifoFull    (wrDoneFifoFull),
        .evtValid          (evtValid),
        .evtReady          (evtReady),
        .evtType           (evtType),
        .evtTid            (evtTid),
        .evtInfo           (evtInfo),
        .ovfErr            (ovfErr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_evt(input string tag, input logic [1:0] ty,
                             input logic [7:0] tid, input logic [19:0] info);
        check({tag, ".valid"}, 32'(evtValid), 32'd1);
        check({tag, ".type"},  32'(evtType),  32'(ty));
        check({tag, ".tid"},   32'(evtTid),   32'(tid));
        check({tag, ".info"},  32'(evtInfo),  32'(info));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    logic [7:0] expTid [8];
    logic [1:0] expTy  [8];

    initial begin
        reset             = 1'b1;
        ackFifoPush       = 1'b0;
        ackFifoDataIn     = '0;
        offloadFifoPush   = 1'b0;
        offloadFifoDataIn = '0;
        wrDoneFifoPush    = 1'b0;
        wrDoneFifoDataIn  = '0;
        evtReady          = 1'b0;

        // Reset state
        do_reset();
        check("rst.valid", 32'(evtValid), 32'd0);
        check("rst.full", 32'({ackFifoFull, offloadFifoFull, wrDoneFifoFull}), 32'd0);
        check("rst.ovf", 32'(ovfErr), 32'd0);
        check("rst.fields", {2'b0, evtType, evtTid, evtInfo}, 32'd0);

        // 1: single ACK, latency t+2, drain
        evtReady      = 1'b1;
        ackFifoPush   = 1'b1;
        ackFifoDataIn = {8'h12, 20'hABCDE};
        step();
        ackFifoPush = 1'b0;
        check("t1.lat1", 32'(evtValid), 32'd0);
        step();
        check_evt("t1.evt", 2'd0, 8'h12, 20'hABCDE);
        step();
        check("t1.drain", 32'(evtValid), 32'd0);

        // 2: simultaneous pushes, RR order ACK/OFFLOAD/WR_DONE
        do_reset();
        ackFifoPush       = 1'b1;
        ackFifoDataIn     = {8'h01, 20'h00055};
        offloadFifoPush   = 1'b1;
        offloadFifoDataIn = 8'h02;
        wrDoneFifoPush    = 1'b1;
        wrDoneFifoDataIn  = 8'h03;
        step();
        ackFifoPush     = 1'b0;
        offloadFifoPush = 1'b0;
        wrDoneFifoPush  = 1'b0;
        step();
        check_evt("t2.e0", 2'd0, 8'h01, 20'h00055);
        step();
        check_evt("t2.e1", 2'd1, 8'h02, 20'd0);
        step();
        check_evt("t2.e2", 2'd2, 8'h03, 20'd0);
        step();
        check("t2.idle", 32'(evtValid), 32'd0);

        // 3: back-pressured offload fill, overflow, in-order release
        do_reset();
        evtReady        = 1'b0;
        offloadFifoPush = 1'b1;
        for (int i = 0; i < 5; i++) begin
            offloadFifoDataIn = 8'(i);
            step();
            if (i == 3) check("t3.notfull", 32'(offloadFifoFull), 32'd0);
        end
        check("t3.full", 32'(offloadFifoFull), 32'd1);
        check("t3.ovf0", 32'(ovfErr), 32'd0);
        check_evt("t3.held", 2'd1, 8'd0, 20'd0);
        offloadFifoDataIn = 8'h55;
        step();
        offloadFifoPush = 1'b0;
        check("t3.ovf1", 32'(ovfErr), 32'd1);
        check("t3.full2", 32'(offloadFifoFull), 32'd1);
        evtReady = 1'b1;
        for (int i = 1; i < 5; i++) begin
            step();
            check_evt($sformatf("t3.out%0d", i), 2'd1, 8'(i), 20'd0);
        end
        check("t3.nfull", 32'(offloadFifoFull), 32'd0);
        step();
        check("t3.idle", 32'(evtValid), 32'd0);
        check("t3.ovfsticky", 32'(ovfErr), 32'd1);

        // 4: ACK and WR_DONE pushed every cycle alternate at output
        do_reset();
        evtReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expTy[2*i]    = 2'd0;
            expTid[2*i]   = 8'h10 + 8'(i);
            expTy[2*i+1]  = 2'd2;
            expTid[2*i+1] = 8'h20 + 8'(i);
        end
        for (int c = 0; c < 9; c++) begin
            ackFifoPush      = (c < 4);
            ackFifoDataIn    = {8'h10 + 8'(c), 20'h0000A};
            wrDoneFifoPush   = (c < 4);
            wrDoneFifoDataIn = 8'h20 + 8'(c);
            step();
            if (c >= 1) begin
                check($sformatf("t4.v%0d", c), 32'(evtValid), 32'd1);
                check($sformatf("t4.ty%0d", c), 32'(evtType), 32'(expTy[c-1]));
                check($sformatf("t4.tid%0d", c), 32'(evtTid), 32'(expTid[c-1]));
            end
        end
        ackFifoPush    = 1'b0;
        wrDoneFifoPush = 1'b0;
        step();
        check("t4.idle", 32'(evtValid), 32'd0);
        check("t4.ovf", 32'(ovfErr), 32'd0);

        // 5: back-pressure toggling
        do_reset();
        evtReady      = 1'b0;
        ackFifoPush   = 1'b1;
        ackFifoDataIn = {8'h31, 20'h00001};
        step();
        ackFifoDataIn = {8'h32, 20'h00002};
        step();
        ackFifoPush = 1'b0;
        check_evt("t5.a", 2'd0, 8'h31, 20'h00001);
        step();
        check_evt("t5.hold", 2'd0, 8'h31, 20'h00001);
        evtReady = 1'b1;
        step();
        check_evt("t5.b", 2'd0, 8'h32, 20'h00002);
        evtReady = 1'b0;
        step();
        check_evt("t5.hold2", 2'd0, 8'h32, 20'h00002);
        evtReady = 1'b1;
        step();
        check("t5.idle", 32'(evtValid), 32'd0);

        // 6: reset with events queued and overflow flagged
        do_reset();
        evtReady    = 1'b0;
        ackFifoPush = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ackFifoDataIn = {8'h40 + 8'(i), 20'h00003};
            step();
        end
        ackFifoPush = 1'b0;
        check("t6.pre.full", 32'(ackFifoFull), 32'd1);
        check("t6.pre.ovf", 32'(ovfErr), 32'd1);
        check("t6.pre.valid", 32'(evtValid), 32'd1);
        reset = 1'b1;
        step();
        check("t6.valid", 32'(evtValid), 32'd0);
        check("t6.full", 32'({ackFifoFull, offloadFifoFull, wrDoneFifoFull}), 32'd0);
        check("t6.ovf", 32'(ovfErr), 32'd0);
        check("t6.fields", {2'b0, evtType, evtTid, evtInfo}, 32'd0);
        reset    = 1'b0;
        evtReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("t6.stale%0d", i), 32'(evtValid), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
